// File: rtl/csi_frame_scheduler.sv
// CSI-2 frame scheduler: emits FS, per-line long packets (header, FIFO payload, CRC
// footer) and FE as a byte stream with valid/ready handshake and HS burst request.
module csi_frame_scheduler #(
    parameter logic [1:0] VIRTUAL_CHANNEL       = 2'h0,
    parameter logic [5:0] PIXEL14BITS_DATA_TYPE = 6'h2D,
    parameter logic [5:0] FRAME_START_DATA_TYPE = 6'h0,
    parameter logic [5:0] FRAME_END_DATA_TYPE   = 6'h1,
    parameter logic [7:0] ECC                   = 8'hCC,
    parameter int         IMAGE_LINES           = 4,
    parameter int         IMAGE_LINE_PIXELS     = 16,
    parameter int         IMAGE_PIXEL_WIDTH     = 14,
    parameter int         IMAGE_LINE_GAP        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        hs_req,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int          WC_INT = IMAGE_LINE_PIXELS * IMAGE_PIXEL_WIDTH / 8;
    localparam logic [15:0] WC     = 16'(WC_INT);
    localparam logic [7:0]  DI_FS  = {VIRTUAL_CHANNEL, FRAME_START_DATA_TYPE};
    localparam logic [7:0]  DI_FE  = {VIRTUAL_CHANNEL, FRAME_END_DATA_TYPE};
    localparam logic [7:0]  DI_LP  = {VIRTUAL_CHANNEL, PIXEL14BITS_DATA_TYPE};
    localparam int          LINE_W = (IMAGE_LINES > 1) ? $clog2(IMAGE_LINES) : 1;
    localparam int          PAY_W  = (WC_INT > 1) ? $clog2(WC_INT) : 1;
    localparam int          GAP_W  = (IMAGE_LINE_GAP > 1) ? $clog2(IMAGE_LINE_GAP) : 1;
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMAGE_LINES - 1);
    localparam logic [PAY_W-1:0]  PAY_LAST  = PAY_W'(WC_INT - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IMAGE_LINE_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_FS, S_GAP, S_LHDR, S_LPAY, S_LFTR, S_FE} state_t;

    state_t            state_q, state_d, next_pkt_q, next_pkt_d, load_state;
    logic [1:0]        byte_idx_q, byte_idx_d, idx_n;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [PAY_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              pay_done_q, pay_done_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]       crc_q, crc_d, frame_cnt_q, frame_cnt_d;
    logic              pending_q, pending_d;
    logic              tx_valid_q, tx_valid_d, tx_sop_q, tx_sop_d, tx_eop_q, tx_eop_d;
    logic              hs_req_q, hs_req_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [31:0]       hdr_bytes;
    logic              xfer, start_req, load_en;

    // Reflected CRC-16/CCITT step over one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // The four bytes of the short packet or long-packet header currently being sent.
    always_comb begin
        hdr_bytes = {ECC, frame_cnt_q[15:8], frame_cnt_q[7:0], DI_FS};
        if (state_q == S_LHDR)    hdr_bytes = {ECC, WC[15:8], WC[7:0], DI_LP};
        else if (state_q == S_FE) hdr_bytes = {ECC, frame_cnt_q[15:8], frame_cnt_q[7:0], DI_FE};
    end

    assign xfer      = tx_valid_q & tx_ready;
    assign start_req = frame_start | pending_q;
    assign idx_n     = byte_idx_q + 2'd1;

    // Next-state, byte sequencing and FIFO pop decision.
    always_comb begin
        state_d     = state_q;
        next_pkt_d  = next_pkt_q;
        byte_idx_d  = byte_idx_q;
        line_cnt_d  = line_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        pay_done_d  = pay_done_q;
        gap_cnt_d   = gap_cnt_q;
        crc_d       = crc_q;
        frame_cnt_d = frame_cnt_q;
        pending_d   = pending_q;
        tx_valid_d  = tx_valid_q;
        tx_sop_d    = tx_sop_q;
        tx_eop_d    = tx_eop_q;
        tx_data_d   = tx_data_q;
        hs_req_d    = hs_req_q;
        fifo_rd     = 1'b0;
        load_en     = 1'b0;
        load_state  = S_FS;

        case (state_q)
            S_IDLE: begin
                if (start_req) load_en = 1'b1;
            end
            S_FS, S_FE, S_LHDR: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        tx_sop_d   = 1'b0;
                        tx_eop_d   = 1'b0;
                        if (state_q == S_LHDR) begin
                            // Long packet continues straight into its payload.
                            state_d    = S_LPAY;
                            pay_cnt_d  = '0;
                            pay_done_d = 1'b0;
                        end else begin
                            hs_req_d   = 1'b0;
                            state_d    = S_GAP;
                            gap_cnt_d  = GAP_LOAD;
                            next_pkt_d = (state_q == S_FS) ? S_LHDR : S_IDLE;
                            if (state_q == S_FE)
                                frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? 16'h0001 : frame_cnt_q + 16'd1;
                        end
                    end else begin
                        byte_idx_d = idx_n;
                        tx_data_d  = hdr_bytes[{idx_n, 3'b000} +: 8];
                        tx_sop_d   = 1'b0;
                        tx_eop_d   = (idx_n == 2'd3) && (state_q != S_LHDR);
                    end
                end
            end
            S_LPAY: begin
                if (!pay_done_q && !fifo_empty && (!tx_valid_q || tx_ready)) begin
                    fifo_rd    = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = fifo_data;
                    crc_d      = crc16_byte(crc_q, fifo_data);
                    if (pay_cnt_q == PAY_LAST) begin
                        pay_cnt_d  = '0;
                        pay_done_d = 1'b1;
                    end else begin
                        pay_cnt_d = pay_cnt_q + PAY_W'(1);
                    end
                end else if (xfer) begin
                    if (pay_done_q) begin
                        // Last payload byte accepted; CRC already covers it.
                        state_d    = S_LFTR;
                        byte_idx_d = 2'd0;
                        tx_data_d  = crc_q[7:0];
                        pay_done_d = 1'b0;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_LFTR: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd0) begin
                        byte_idx_d = 2'd1;
                        tx_data_d  = crc_q[15:8];
                        tx_eop_d   = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        tx_eop_d   = 1'b0;
                        hs_req_d   = 1'b0;
                        state_d    = S_GAP;
                        gap_cnt_d  = GAP_LOAD;
                        if (line_cnt_q == LINE_LAST) begin
                            line_cnt_d = '0;
                            next_pkt_d = S_FE;
                        end else begin
                            line_cnt_d = line_cnt_q + LINE_W'(1);
                            next_pkt_d = S_LHDR;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (next_pkt_q != S_IDLE) begin
                        load_en    = 1'b1;
                        load_state = next_pkt_q;
                    end else if (start_req) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            state_d    = load_state;
            byte_idx_d = 2'd0;
            tx_valid_d = 1'b1;
            tx_sop_d   = 1'b1;
            tx_eop_d   = 1'b0;
            hs_req_d   = 1'b1;
            case (load_state)
                S_FS: begin
                    tx_data_d  = DI_FS;
                    line_cnt_d = '0;
                    pay_cnt_d  = '0;
                    pay_done_d = 1'b0;
                end
                S_FE:    tx_data_d = DI_FE;
                default: begin
                    tx_data_d = DI_LP;
                    crc_d     = 16'hFFFF;
                end
            endcase
        end

        // A start consumed this cycle clears the request; otherwise remember one.
        if (load_en && load_state == S_FS) pending_d = 1'b0;
        else if (frame_start && state_q != S_IDLE) pending_d = 1'b1;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_pkt_q  <= S_IDLE;
            byte_idx_q  <= 2'd0;
            line_cnt_q  <= '0;
            pay_cnt_q   <= '0;
            pay_done_q  <= 1'b0;
            gap_cnt_q   <= '0;
            crc_q       <= 16'h0000;
            frame_cnt_q <= 16'h0001;
            pending_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_data_q   <= 8'h00;
            hs_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_pkt_q  <= next_pkt_d;
            byte_idx_q  <= byte_idx_d;
            line_cnt_q  <= line_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            pay_done_q  <= pay_done_d;
            gap_cnt_q   <= gap_cnt_d;
            crc_q       <= crc_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
            tx_valid_q  <= tx_valid_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_data_q   <= tx_data_d;
            hs_req_q    <= hs_req_d;
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_sop    = tx_sop_q;
    assign tx_eop    = tx_eop_q;
    assign tx_data   = tx_data_q;
    assign hs_req    = hs_req_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != S_IDLE) || pending_q;

endmodule

// File: tb/tb_csi_frame_scheduler.sv
// Directed bench for csi_frame_scheduler: byte stream, gaps, stalls, pending, reset, wrap.
module tb_csi_frame_scheduler;

    logic        clk, rst, frame_start, fifo_empty, tx_ready;
    logic [7:0]  fifo_data;
    logic        fifo_rd, tx_valid, tx_sop, tx_eop, hs_req, busy;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;

    csi_frame_scheduler dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .hs_req(hs_req),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] pop_cnt = 0;
    bit          fifo_inc = 1'b0;
    always @(posedge clk) if (fifo_rd) pop_cnt <= pop_cnt + 1;
    assign fifo_data = fifo_inc ? pop_cnt[7:0] : 8'h00;

    logic [9:0] got[$];
    logic [9:0] exp_q[$];

    bit         fs_req, rand_ready, stall_arm, have_eop, in_pkt, prev_stall, sop_new;
    int         cyc, last_eop, emp_cnt, lo_cnt;
    logic [31:0] pop_base, snap_pop;
    int         snap_len;
    logic [7:0] prev_data;
    logic [2:0] prev_ctl;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c, n;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb    = c[0] ^ d[i];
            n     = {1'b0, c[15:1]};
            n[15] = fb;
            n[10] = n[10] ^ fb;
            n[3]  = n[3] ^ fb;
            c     = n;
        end
        return c;
    endfunction

    // Expected {sop, eop, data} stream of one frame.
    task automatic add_frame(input logic [15:0] fn, input bit inc, input logic [31:0] base);
        logic [15:0] crc;
        logic [7:0]  d;
        exp_q.push_back({2'b10, 8'h00});
        exp_q.push_back({2'b00, fn[7:0]});
        exp_q.push_back({2'b00, fn[15:8]});
        exp_q.push_back({2'b01, 8'hCC});
        for (int l = 0; l < 4; l++) begin
            exp_q.push_back({2'b10, 8'h2D});
            exp_q.push_back({2'b00, 8'h1C});
            exp_q.push_back({2'b00, 8'h00});
            exp_q.push_back({2'b00, 8'hCC});
            crc = 16'hFFFF;
            for (int b = 0; b < 28; b++) begin
                d   = inc ? 8'(base + 32'(l * 28 + b)) : 8'h00;
                crc = crc_model(crc, d);
                exp_q.push_back({2'b00, d});
            end
            exp_q.push_back({2'b00, crc[7:0]});
            exp_q.push_back({2'b01, crc[15:8]});
        end
        exp_q.push_back({2'b10, 8'h01});
        exp_q.push_back({2'b00, fn[7:0]});
        exp_q.push_back({2'b00, fn[15:8]});
        exp_q.push_back({2'b01, 8'hCC});
    endtask

    task automatic compare_stream(input string tag);
        check_eq({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic clear_mon();
        have_eop   = 1'b0;
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, then sample and monitor.
    task automatic tick();
        @(negedge clk);
        frame_start = fs_req;
        fs_req      = 1'b0;
        tx_ready    = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (stall_arm && (pop_cnt - pop_base == 32'd10)) begin
            stall_arm = 1'b0;
            emp_cnt   = 5;
            lo_cnt    = 6;
        end
        fifo_empty = (emp_cnt > 0);
        if (emp_cnt > 0) emp_cnt--;
        #1;
        cyc++;
        if (prev_stall) begin
            check_eq("hold_data", 32'(tx_data), 32'(prev_data));
            check_eq("hold_ctl", 32'({tx_valid, tx_sop, tx_eop}), 32'(prev_ctl));
        end
        sop_new = tx_valid && tx_sop && !prev_stall;
        if (sop_new) begin
            in_pkt = 1'b1;
            if (have_eop) check_eq("gap_len", 32'(cyc - last_eop - 1), 32'd8);
        end
        check_eq("hs_req", 32'(hs_req), 32'(in_pkt));
        if (lo_cnt > 0) begin
            if (lo_cnt <= 5) begin
                check_eq("stall_valid", 32'(tx_valid), 32'd0);
                check_eq("stall_hs", 32'(hs_req), 32'd1);
            end
            lo_cnt--;
        end
        if (fifo_empty) check_eq("empty_rd", 32'(fifo_rd), 32'd0);
        if (tx_valid && tx_ready) begin
            got.push_back({tx_sop, tx_eop, tx_data});
            if (tx_eop) begin
                in_pkt   = 1'b0;
                have_eop = 1'b1;
                last_eop = cyc;
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_ctl   = {tx_valid, tx_sop, tx_eop};
    endtask

    // Pulse frame_start and confirm the FS DI byte one cycle later.
    task automatic start_frame();
        have_eop = 1'b0;
        fs_req   = 1'b1;
        tick();
        tick();
        check_eq("fs_latency", 32'({tx_valid, tx_sop, tx_data}), 32'({2'b11, 8'h00}));
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        if (busy) check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; fifo_empty = 1'b0; tx_ready = 1'b1;
        fs_req = 1'b0; rand_ready = 1'b0; stall_arm = 1'b0;
        emp_cnt = 0; lo_cnt = 0; cyc = 0; last_eop = 0; pop_base = 0;
        clear_mon();
        #1;
        check_eq("rst_tx", 32'({tx_valid, tx_sop, tx_eop, tx_data}), 32'd0);
        check_eq("rst_ctl", 32'({hs_req, busy, fifo_rd}), 32'd0);
        check_eq("rst_frame_cnt", 32'(frame_cnt), 32'h0001);
        reset_dut();
        repeat (5) tick();
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_valid", 32'(tx_valid), 32'd0);

        // Frame 1, always ready, zero payload.
        add_frame(16'h0001, 1'b0, 0);
        start_frame();
        run_until_idle(2000);
        compare_stream("f1");
        check_eq("f1_cnt", 32'(frame_cnt), 32'h0002);

        // Frame 2 with random back-pressure.
        rand_ready = 1'b1;
        add_frame(16'h0002, 1'b0, 0);
        start_frame();
        run_until_idle(4000);
        rand_ready = 1'b0;
        compare_stream("f2");
        check_eq("f2_cnt", 32'(frame_cnt), 32'h0003);

        // Frame 3, counting payload with a 5-cycle underflow at byte 10.
        fifo_inc  = 1'b1;
        pop_base  = pop_cnt;
        stall_arm = 1'b1;
        add_frame(16'h0003, 1'b1, pop_base);
        start_frame();
        run_until_idle(2000);
        check_eq("stall_seen", 32'(stall_arm), 32'd0);
        compare_stream("f3");
        fifo_inc = 1'b0;

        // Three requests during one frame give exactly two back-to-back frames.
        reset_dut();
        add_frame(16'h0001, 1'b0, 0);
        add_frame(16'h0002, 1'b0, 0);
        start_frame();
        repeat (20) tick();
        fs_req = 1'b1;
        repeat (40) tick();
        fs_req = 1'b1;
        run_until_idle(4000);
        compare_stream("pend");
        check_eq("pend_cnt", 32'(frame_cnt), 32'h0003);
        repeat (30) tick();
        check_eq("pend_no_third", 32'({busy, tx_valid}), 32'd0);
        check_eq("pend_no_bytes", 32'(got.size()), 32'd0);

        // Reset in the middle of line 2 payload.
        start_frame();
        begin
            int n;
            n = 0;
            while (got.size() < 86 && n < 1000) begin
                tick();
                n++;
            end
        end
        check_eq("mid_reached", 32'(got.size() >= 86), 32'd1);
        #2;
        rst = 1'b1;
        clear_mon();
        #1;
        check_eq("mid_rst_tx", 32'({tx_valid, tx_sop, tx_eop, tx_data}), 32'd0);
        check_eq("mid_rst_ctl", 32'({hs_req, busy, fifo_rd}), 32'd0);
        check_eq("mid_rst_cnt", 32'(frame_cnt), 32'h0001);
        snap_pop = pop_cnt;
        snap_len = got.size();
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check_eq("mid_no_pop", pop_cnt, snap_pop);
        check_eq("mid_no_eop", 32'(got.size()), 32'(snap_len));
        check_eq("mid_idle", 32'(busy), 32'd0);
        got.delete();
        add_frame(16'h0001, 1'b0, 0);
        start_frame();
        run_until_idle(2000);
        compare_stream("after_rst");
        check_eq("after_rst_cnt", 32'(frame_cnt), 32'h0002);

        // Frame counter wrap: FFFF -> 0001.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        tick();
        check_eq("wrap_preset", 32'(frame_cnt), 32'hFFFF);
        add_frame(16'hFFFF, 1'b0, 0);
        start_frame();
        run_until_idle(2000);
        compare_stream("wrap_ff");
        check_eq("wrap_cnt", 32'(frame_cnt), 32'h0001);
        add_frame(16'h0001, 1'b0, 0);
        start_frame();
        run_until_idle(2000);
        compare_stream("wrap_01");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
